// File: rtl/seq_hit_logger_pkg.sv
// -----------------------------------------------------------------------------
// seq_hit_pkg
// Shared definitions for the sequence-hit logger:
//   - default timestamp / counter widths
//   - timestamp type at the default width
//   - saturating increment helper used by the hit and drop counters
// -----------------------------------------------------------------------------
package seq_hit_pkg;

    localparam int TS_W_DEF  = 16;
    localparam int CNT_W_DEF = 8;

    typedef logic [TS_W_DEF-1:0] seq_ts_t;

    // Increment val by one unless it already sits at max_val. Operands are
    // 32 bits wide so any counter up to 32 bits can share this helper; the
    // caller truncates the result back to its own width.
    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic [31:0] max_val);
        logic [31:0] res;
        if (val >= max_val) begin
            res = max_val;
        end else begin
            res = val + 32'd1;
        end
        return res;
    endfunction

endpackage

// File: rtl/seq_hit_logger_if.sv
// -----------------------------------------------------------------------------
// seq_hit_logger_if
// Read-side valid/ready port through which the host drains logged timestamps.
//   rd_valid  : head entry present (driven by the logger)
//   rd_ready  : host accepts the head when rd_valid is also high
//   rd_data   : timestamp at the FIFO head, TS_W bits
// master = logger side, slave = consumer side.
// -----------------------------------------------------------------------------
interface seq_hit_logger_if #(
    parameter int TS_W = 16
);
    logic            rd_valid;
    logic            rd_ready;
    logic [TS_W-1:0] rd_data;

    modport master (
        output rd_valid,
        output rd_data,
        input  rd_ready
    );

    modport slave (
        input  rd_valid,
        input  rd_data,
        output rd_ready
    );
endinterface

// File: rtl/seq_hit_logger_fifo.sv
// -----------------------------------------------------------------------------
// seq_hit_fifo
// Synchronous FIFO with explicit occupancy counter and registered head.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   push_i, wdata_i : write request and data
//   pop_i           : consumer ready; a pop happens only when the head is valid
//   clr_i           : synchronous flush; push/pop in the same cycle ignored
//   head_o          : registered head data (holds while empty)
//   head_valid_o    : FIFO not empty
//   level_o         : registered occupancy
//   level_next_o    : occupancy after this cycle's update (for registered
//                     derived flags in the parent)
//   full_o          : level == DEPTH
//   accept_o        : push stored this cycle
//   drop_o          : an entry was lost this cycle (newest or oldest)
// Build option SEQ_HIT_LOGGER_OVERWRITE_EN: a push into a full FIFO without
// a pop overwrites the oldest entry instead of discarding the new one.
// -----------------------------------------------------------------------------
module seq_hit_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     clr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    output logic [WIDTH-1:0]         head_o,
    output logic                     head_valid_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic [$clog2(DEPTH):0]   level_next_o,
    output logic                     full_o,
    output logic                     accept_o,
    output logic                     drop_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic             full_q, full_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] head_q, head_d;

    logic pop_ok_s;
    logic push_ok_s;
    logic ovw_s;
    logic drop_s;
    logic rd_adv_s;

    // Decide which of push / pop / overwrite actually take effect this cycle.
    always_comb begin
        pop_ok_s = pop_i && valid_q && !clr_i;
        drop_s   = push_i && !clr_i && full_q && !pop_ok_s;
`ifdef SEQ_HIT_LOGGER_OVERWRITE_EN
        // Full without pop: store anyway and retire the oldest entry.
        push_ok_s = push_i && !clr_i;
        ovw_s     = drop_s;
`else
        // Full without pop: the new entry is discarded.
        push_ok_s = push_i && !clr_i && (!full_q || pop_ok_s);
        ovw_s     = 1'b0;
`endif
        rd_adv_s = pop_ok_s || ovw_s;
    end

    // Next-state for pointers, occupancy, flags and the registered head.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        head_d   = head_q;
        if (clr_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            level_d  = {LVL_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_adv_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            if (push_ok_s && !rd_adv_s) begin
                level_d = level_q + LVL_W'(1);
            end else if (rd_adv_s && !push_ok_s) begin
                level_d = level_q - LVL_W'(1);
            end else begin
                level_d = level_q;
            end
        end
        // The new head is either the entry being written right now (FIFO
        // empty, or draining its last entry while writing) or an entry
        // already in storage. When the FIFO goes empty the head holds.
        if (level_d != {LVL_W{1'b0}}) begin
            if (push_ok_s && (rd_ptr_d == wr_ptr_q)) begin
                head_d = wdata_i;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end else begin
            head_d = head_q;
        end
        full_d  = (level_d == LVL_W'(DEPTH));
        valid_d = (level_d != {LVL_W{1'b0}});
    end

    // Control and head registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            level_q  <= {LVL_W{1'b0}};
            full_q   <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= {WIDTH{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            valid_q  <= valid_d;
            head_q   <= head_d;
        end
    end

    // Storage array; contents are only meaningful below the occupancy count,
    // so it carries no reset.
    always_ff @(posedge clk) begin
        if (push_ok_s && !rst) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign head_o       = head_q;
    assign head_valid_o = valid_q;
    assign level_o      = level_q;
    assign level_next_o = level_d;
    assign full_o       = full_q;
    assign accept_o     = push_ok_s;
    assign drop_o       = drop_s;

endmodule

// File: rtl/seq_hit_logger.sv
// -----------------------------------------------------------------------------
// seq_hit_logger
// Timestamps each detector hit pulse with a free-running cycle counter and
// queues the timestamps for the host. Keeps saturating accepted-hit and
// dropped-hit counters and a level-sensitive occupancy interrupt.
// Ports:
//   clk, rst    : clock, synchronous active-high reset (overrides everything)
//   hit_i       : one-cycle detection pulse
//   clr_i       : synchronous flush of FIFO and counters (timestamp unaffected)
//   rd_if       : valid/ready drain port (master side)
//   level_o     : registered FIFO occupancy
//   full_o      : level_o == DEPTH
//   hit_cnt_o   : accepted pushes, saturating
//   drop_cnt_o  : entries lost to a full FIFO, saturating
//   irq_o       : level_o >= THRESH
// Build option SEQ_HIT_LOGGER_OVERWRITE_EN (handled in seq_hit_fifo): full
// FIFO overwrites its oldest entry instead of dropping the newest hit.
// -----------------------------------------------------------------------------
module seq_hit_logger
    import seq_hit_pkg::*;
#(
    parameter int TS_W   = TS_W_DEF,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = CNT_W_DEF,
    parameter int THRESH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hit_i,
    input  logic                   clr_i,
    seq_hit_logger_if.master       rd_if,
    output logic [$clog2(DEPTH):0] level_o,
    output logic                   full_o,
    output logic [CNT_W-1:0]       hit_cnt_o,
    output logic [CNT_W-1:0]       drop_cnt_o,
    output logic                   irq_o
);

    localparam int LVL_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [TS_W-1:0]  ts_q, ts_d;
    logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             irq_q, irq_d;

    logic [TS_W-1:0]  head_s;
    logic             head_valid_s;
    logic [LVL_W-1:0] level_s;
    logic [LVL_W-1:0] level_next_s;
    logic             full_s;
    logic             accept_s;
    logic             drop_s;

    seq_hit_fifo #(
        .WIDTH (TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (hit_i),
        .pop_i        (rd_if.rd_ready),
        .clr_i        (clr_i),
        .wdata_i      (ts_q),
        .head_o       (head_s),
        .head_valid_o (head_valid_s),
        .level_o      (level_s),
        .level_next_o (level_next_s),
        .full_o       (full_s),
        .accept_o     (accept_s),
        .drop_o       (drop_s)
    );

    // Next-state for the timestamp, the two counters and the interrupt.
    always_comb begin
        ts_d = ts_q + TS_W'(1);
        if (clr_i) begin
            hit_cnt_d  = {CNT_W{1'b0}};
            drop_cnt_d = {CNT_W{1'b0}};
        end else begin
            if (accept_s) begin
                hit_cnt_d = CNT_W'(sat_inc(32'(hit_cnt_q), 32'(CNT_MAX)));
            end else begin
                hit_cnt_d = hit_cnt_q;
            end
            if (drop_s) begin
                drop_cnt_d = CNT_W'(sat_inc(32'(drop_cnt_q), 32'(CNT_MAX)));
            end else begin
                drop_cnt_d = drop_cnt_q;
            end
        end
        // Taken from the FIFO's next occupancy so irq lines up with level_o.
        irq_d = (level_next_s >= LVL_W'(THRESH));
    end

    // Timestamp, counter and interrupt registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q       <= {TS_W{1'b0}};
            hit_cnt_q  <= {CNT_W{1'b0}};
            drop_cnt_q <= {CNT_W{1'b0}};
            irq_q      <= 1'b0;
        end else begin
            ts_q       <= ts_d;
            hit_cnt_q  <= hit_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            irq_q      <= irq_d;
        end
    end

    assign rd_if.rd_valid = head_valid_s;
    assign rd_if.rd_data  = head_s;
    assign level_o        = level_s;
    assign full_o         = full_s;
    assign hit_cnt_o      = hit_cnt_q;
    assign drop_cnt_o     = drop_cnt_q;
    assign irq_o          = irq_q;

endmodule

// File: tb/tb_seq_hit_logger.sv
// -----------------------------------------------------------------------------
// tb_seq_hit_logger
// Two loggers (16-bit and 4-bit timestamps) share one stimulus stream and are
// compared every cycle against a queue-based reference model that stores the
// absolute cycle number of each accepted hit.
// -----------------------------------------------------------------------------
module tb_seq_hit_logger;
    import seq_hit_pkg::*;

    localparam int DEPTH  = 8;
    localparam int CNT_W  = 8;
    localparam int THRESH = 4;
    localparam int TSA    = TS_W_DEF;
    localparam int TSB    = 4;
    localparam int LVL_W  = $clog2(DEPTH) + 1;
    localparam int CMAX   = 255;

    logic clk = 1'b0;
    logic rst, hit, clr, rdy;

    logic [LVL_W-1:0] level_a, level_b;
    logic             full_a, full_b, irq_a, irq_b;
    logic [CNT_W-1:0] hc_a, hc_b, dc_a, dc_b;

    seq_hit_logger_if #(.TS_W(TSA)) ifa ();
    seq_hit_logger_if #(.TS_W(TSB)) ifb ();

    assign ifa.rd_ready = rdy;
    assign ifb.rd_ready = rdy;

    seq_hit_logger #(.TS_W(TSA), .DEPTH(DEPTH), .CNT_W(CNT_W), .THRESH(THRESH)) dut_a (
        .clk(clk), .rst(rst), .hit_i(hit), .clr_i(clr), .rd_if(ifa.master),
        .level_o(level_a), .full_o(full_a), .hit_cnt_o(hc_a), .drop_cnt_o(dc_a), .irq_o(irq_a)
    );

    seq_hit_logger #(.TS_W(TSB), .DEPTH(DEPTH), .CNT_W(CNT_W), .THRESH(THRESH)) dut_b (
        .clk(clk), .rst(rst), .hit_i(hit), .clr_i(clr), .rd_if(ifb.master),
        .level_o(level_b), .full_o(full_b), .hit_cnt_o(hc_b), .drop_cnt_o(dc_b), .irq_o(irq_b)
    );

    always #5 clk = ~clk;

    // Reference model state.
    int unsigned mq[$];
    int unsigned m_hits, m_drops, m_cyc;
    bit          m_after_rst;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d (model cycle %0d)", tag, act, exp, m_cyc);
        end
    endtask

    function automatic int unsigned sat(input int unsigned v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    // One clock cycle: compare outputs, drive inputs, advance the model.
    task automatic step(input logic h, input logic r, input logic c, input logic s);
        int unsigned n;
        @(negedge clk);
        n = mq.size();
        check_eq("valid_a", ifa.rd_valid, (n != 0));
        check_eq("valid_b", ifb.rd_valid, (n != 0));
        check_eq("level_a", level_a, n);
        check_eq("level_b", level_b, n);
        check_eq("full_a", full_a, (n == DEPTH));
        check_eq("full_b", full_b, (n == DEPTH));
        check_eq("irq_a", irq_a, (n >= THRESH));
        check_eq("irq_b", irq_b, (n >= THRESH));
        check_eq("hitcnt_a", hc_a, m_hits);
        check_eq("hitcnt_b", hc_b, m_hits);
        check_eq("dropcnt_a", dc_a, m_drops);
        check_eq("dropcnt_b", dc_b, m_drops);
        if (n != 0) begin
            check_eq("data_a", ifa.rd_data, mq[0] % 65536);
            check_eq("data_b", ifb.rd_data, mq[0] % 16);
        end else if (m_after_rst) begin
            check_eq("rstdata_a", ifa.rd_data, 32'd0);
            check_eq("rstdata_b", ifb.rd_data, 32'd0);
        end

        hit = h;
        rdy = r;
        clr = c;
        rst = s;

        if (s) begin
            mq.delete();
            m_hits      = 0;
            m_drops     = 0;
            m_cyc       = 0;
            m_after_rst = 1'b1;
        end else begin
            if (c) begin
                mq.delete();
                m_hits  = 0;
                m_drops = 0;
            end else begin
                if (r && (mq.size() != 0)) begin
                    void'(mq.pop_front());
                    m_after_rst = 1'b0;
                end
                if (h) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(m_cyc);
                        m_hits = sat(m_hits);
                    end else begin
`ifdef SEQ_HIT_LOGGER_OVERWRITE_EN
                        void'(mq.pop_front());
                        mq.push_back(m_cyc);
                        m_hits = sat(m_hits);
`endif
                        m_drops = sat(m_drops);
                    end
                    m_after_rst = 1'b0;
                end
            end
            m_cyc++;
        end
    endtask

    initial begin
        int rp;
        rst = 1'b1;
        hit = 1'b0;
        clr = 1'b0;
        rdy = 1'b0;
        m_hits      = 0;
        m_drops     = 0;
        m_cyc       = 0;
        m_after_rst = 1'b1;
        repeat (2) @(posedge clk);

        // Hits at cycles 3,5,6,7,9 with no consumer.
        for (int k = 0; k < 10; k++) begin
            step((k == 3) || (k == 5) || (k == 6) || (k == 7) || (k == 9), 1'b0, 1'b0, 1'b0);
        end
        // Drain all five.
        repeat (6) step(1'b0, 1'b1, 1'b0, 1'b0);
        // Fill to DEPTH then two more hits while full (crosses the 4-bit wrap).
        repeat (10) step(1'b1, 1'b0, 1'b0, 1'b0);
        // Full with simultaneous hit and pop.
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        // Down to three entries, then clear together with a hit.
        repeat (5) step(1'b0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Random traffic with bursty consumer and rare clear / reset.
        rp = 50;
        for (int i = 0; i < 3000; i++) begin
            if ((i % 100) == 0) begin
                rp = $urandom_range(5, 95);
            end
            step(1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 99) < rp),
                 1'($urandom_range(0, 199) == 0),
                 1'($urandom_range(0, 499) == 0));
        end

        // Hit-counter saturation: 300 accepted hits.
        step(1'b0, 1'b0, 1'b1, 1'b0);
        repeat (300) step(1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("hit_sat", hc_a, 32'd255);
        // Drop-counter saturation: 300 hits with no consumer.
        repeat (300) step(1'b1, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_eq("drop_sat", dc_a, 32'd255);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
